// File: rtl/my_accum_if.sv
// ---------------------------------------------------------------------------
// my_accum_if
// Purpose : Bundles the job-control, product-input and result-handshake
//           signals of the my_accum product accumulator.
// Signals : start      - one-cycle pulse that begins a job (master -> slave)
//           len        - number of products in the job   (master -> slave)
//           din        - unsigned product, 2*BITWIDTH    (master -> slave)
//           din_valid  - din carries a product this cycle (master -> slave)
//           dout_ready - downstream accepts the result   (master -> slave)
//           dout       - accumulated sum, ACCWIDTH bits  (slave -> master)
//           dout_valid - result available                (slave -> master)
//           busy       - a job is in progress            (slave -> master)
//           ovf        - sticky carry-out of the current job (slave -> master)
// ---------------------------------------------------------------------------
interface my_accum_if #(
    parameter int BITWIDTH = 32,
    parameter int GUARD    = 8,
    parameter int LENWIDTH = 8
);
    localparam int ACCWIDTH = 2 * BITWIDTH + GUARD;

    logic                  start;
    logic [LENWIDTH-1:0]   len;
    logic [2*BITWIDTH-1:0] din;
    logic                  din_valid;
    logic [ACCWIDTH-1:0]   dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  busy;
    logic                  ovf;

    modport master (
        output start, len, din, din_valid, dout_ready,
        input  dout, dout_valid, busy, ovf
    );

    modport slave (
        input  start, len, din, din_valid, dout_ready,
        output dout, dout_valid, busy, ovf
    );
endinterface

// File: rtl/my_accum.sv
// ---------------------------------------------------------------------------
// my_accum
// Purpose : Sums a job of 'len' unsigned products arriving on din/din_valid
//           into an ACCWIDTH-bit accumulator (ACCWIDTH = 2*BITWIDTH+GUARD),
//           then presents the sum with a valid/ready handshake.
//           A carry out of the accumulator sets a sticky ovf flag for the job;
//           the sum wraps modulo 2^ACCWIDTH.
// Ports   : clk  - rising-edge clock for all state
//           rstn - asynchronous active-low reset
//           bus  - my_accum_if slave modport (start, len, din, din_valid,
//                  dout_ready in; dout, dout_valid, busy, ovf out)
// ---------------------------------------------------------------------------
module my_accum #(
    parameter int BITWIDTH = 32,
    parameter int GUARD    = 8,
    parameter int LENWIDTH = 8
) (
    input  logic        clk,
    input  logic        rstn,
    my_accum_if.slave   bus
);
    localparam int ACCWIDTH = 2 * BITWIDTH + GUARD;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ACCWIDTH-1:0]   r_acc;
    logic [LENWIDTH-1:0]   r_remaining;
    logic                  r_ovf;

    logic                  w_start_ok;
    logic                  w_take;
    logic                  w_last;
    logic                  w_handshake;
    logic [ACCWIDTH:0]     w_sum;

    // Start is only accepted from IDLE, so a start coinciding with the DONE
    // handshake is dropped: the state is still DONE in that cycle.
    assign w_start_ok  = (r_state == S_IDLE) && bus.start;
    assign w_take      = (r_state == S_ACCUM) && bus.din_valid;
    assign w_last      = w_take && (r_remaining == LENWIDTH'(1));
    assign w_handshake = (r_state == S_DONE) && bus.dout_ready;

    // One extra bit captures the carry out of the accumulator.
    assign w_sum = {1'b0, r_acc} + {{(GUARD + 1){1'b0}}, bus.din};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next_state = (bus.len == '0) ? S_DONE : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (w_handshake) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_acc       <= '0;
            r_remaining <= '0;
            r_ovf       <= 1'b0;
        end else if (w_start_ok) begin
            r_acc       <= '0;
            r_remaining <= bus.len;
            r_ovf       <= 1'b0;
        end else if (w_take) begin
            r_acc       <= w_sum[ACCWIDTH-1:0];
            r_remaining <= r_remaining - LENWIDTH'(1);
            r_ovf       <= r_ovf | w_sum[ACCWIDTH];
        end
    end

    // dout comes straight from the register, so dout_valid (decoded from the
    // state register) and the final sum both appear on the same edge.
    assign bus.dout       = r_acc;
    assign bus.dout_valid = (r_state == S_DONE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.ovf        = r_ovf;
endmodule

// File: tb/tb_my_accum.sv
module tb_my_accum;
    localparam int BW   = 32;
    localparam int LW   = 8;
    localparam int AW_A = 2 * BW + 8;
    localparam int AW_B = 2 * BW;

    logic clk;
    logic rstn;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    my_accum_if #(.BITWIDTH(BW), .GUARD(8), .LENWIDTH(LW)) bus_a ();
    my_accum_if #(.BITWIDTH(BW), .GUARD(0), .LENWIDTH(LW)) bus_b ();

    my_accum #(.BITWIDTH(BW), .GUARD(8), .LENWIDTH(LW)) dut_a (
        .clk (clk),
        .rstn(rstn),
        .bus (bus_a)
    );

    my_accum #(.BITWIDTH(BW), .GUARD(0), .LENWIDTH(LW)) dut_b (
        .clk (clk),
        .rstn(rstn),
        .bus (bus_b)
    );

    // Both instances see identical stimulus.
    logic          d_start;
    logic [LW-1:0] d_len;
    logic [63:0]   d_din;
    logic          d_valid;
    logic          d_ready;

    assign bus_a.start      = d_start;
    assign bus_a.len        = d_len;
    assign bus_a.din        = d_din;
    assign bus_a.din_valid  = d_valid;
    assign bus_a.dout_ready = d_ready;
    assign bus_b.start      = d_start;
    assign bus_b.len        = d_len;
    assign bus_b.din        = d_din;
    assign bus_b.din_valid  = d_valid;
    assign bus_b.dout_ready = d_ready;

    typedef struct {
        logic [127:0] d;
        logic         o;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [63:0] terms_q[$];
    bit          pat_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the exact sum of the job's terms; each instance reports it
    // modulo 2^ACCWIDTH and flags ovf when the exact sum does not fit.
    task automatic push_exp(input logic [127:0] sum);
        exp_t e;
        e.d = sum & ((128'd1 << AW_A) - 128'd1);
        e.o = (sum >> AW_A) != 0;
        qa.push_back(e);
        e.d = sum & ((128'd1 << AW_B) - 128'd1);
        e.o = (sum >> AW_B) != 0;
        qb.push_back(e);
    endtask

    // Scoreboard monitors: compare on every accepted result.
    always @(negedge clk) begin
        if (rstn === 1'b1 && bus_a.dout_valid === 1'b1 && bus_a.dout_ready === 1'b1) begin
            exp_t e;
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_result: got 0x%0h expected no result", bus_a.dout);
            end else begin
                e = qa.pop_front();
                check("a_dout", 128'(bus_a.dout), e.d);
                check("a_ovf", 128'(bus_a.ovf), 128'(e.o));
            end
        end
    end

    always @(negedge clk) begin
        if (rstn === 1'b1 && bus_b.dout_valid === 1'b1 && bus_b.dout_ready === 1'b1) begin
            exp_t e;
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_result: got 0x%0h expected no result", bus_b.dout);
            end else begin
                e = qb.pop_front();
                check("b_dout", 128'(bus_b.dout), e.d);
                check("b_ovf", 128'(bus_b.ovf), 128'(e.o));
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_a_dout"},  128'(bus_a.dout), 0);
        check({tag, "_a_valid"}, 128'(bus_a.dout_valid), 0);
        check({tag, "_a_busy"},  128'(bus_a.busy), 0);
        check({tag, "_a_ovf"},   128'(bus_a.ovf), 0);
        check({tag, "_b_dout"},  128'(bus_b.dout), 0);
        check({tag, "_b_valid"}, 128'(bus_b.dout_valid), 0);
        check({tag, "_b_busy"},  128'(bus_b.busy), 0);
        check({tag, "_b_ovf"},   128'(bus_b.ovf), 0);
    endtask

    // Runs one job using terms_q (and pat_q as din_valid pattern if filled),
    // holds dout_ready low for bp cycles in DONE, then accepts the result
    // while also pulsing start (which must be ignored).
    task automatic do_job(input int len, input int bp);
        logic [127:0] sum = '0;
        logic [127:0] hold_a;
        logic [127:0] hold_b;
        int           idx = 0;
        bit           v;

        d_start = 1'b1;
        d_len   = len[LW-1:0];
        d_valid = 1'b0;
        d_ready = 1'($urandom_range(0, 1));
        tick();
        d_start = 1'b0;
        d_ready = 1'b0;
        check("a_busy_after_start", 128'(bus_a.busy), 1);
        check("b_busy_after_start", 128'(bus_b.busy), 1);
        check("a_ovf_after_start", 128'(bus_a.ovf), 0);
        check("b_ovf_after_start", 128'(bus_b.ovf), 0);
        if (len == 0) push_exp(sum);

        while (idx < len) begin
            if (pat_q.size() != 0) v = pat_q.pop_front();
            else                   v = ($urandom_range(0, 3) != 0);
            d_valid = v;
            d_din   = v ? terms_q[idx] : {$urandom, $urandom};
            d_ready = 1'($urandom_range(0, 1));
            d_start = 1'($urandom_range(0, 1));
            if (v) begin
                sum += 128'(terms_q[idx]);
                idx++;
                if (idx == len) push_exp(sum);
            end
            tick();
        end
        d_valid = 1'b0;
        d_ready = 1'b0;
        d_start = 1'b0;

        check("a_valid_latency", 128'(bus_a.dout_valid), 1);
        check("b_valid_latency", 128'(bus_b.dout_valid), 1);
        hold_a = 128'(bus_a.dout);
        hold_b = 128'(bus_b.dout);

        for (int i = 0; i < bp; i++) begin
            d_valid = 1'b1;
            d_din   = {$urandom, $urandom};
            d_start = 1'($urandom_range(0, 1));
            d_len   = LW'($urandom_range(0, 255));
            tick();
            check("a_hold_valid", 128'(bus_a.dout_valid), 1);
            check("a_hold_dout", 128'(bus_a.dout), hold_a);
            check("b_hold_dout", 128'(bus_b.dout), hold_b);
        end

        d_ready = 1'b1;
        d_start = 1'b1;
        d_len   = LW'($urandom_range(1, 255));
        d_valid = 1'b1;
        tick();
        d_ready = 1'b0;
        d_start = 1'b0;
        d_valid = 1'b0;
        check("a_valid_after_hs", 128'(bus_a.dout_valid), 0);
        check("a_busy_after_hs", 128'(bus_a.busy), 0);
        check("b_busy_after_hs", 128'(bus_b.busy), 0);
        terms_q.delete();
        pat_q.delete();
    endtask

    initial begin
        rstn    = 1'b0;
        d_start = 1'b0;
        d_len   = '0;
        d_din   = '0;
        d_valid = 1'b0;
        d_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Basic job: 1+2+3+4.
        terms_q = '{64'd1, 64'd2, 64'd3, 64'd4};
        pat_q   = '{1'b1, 1'b1, 1'b1, 1'b1};
        do_job(4, 0);

        // Bubbles with all-ones products.
        terms_q = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        pat_q   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_job(3, 0);

        // Backpressure.
        terms_q = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321};
        do_job(2, 5);

        // Zero length.
        do_job(0, 0);

        // Overflow in the GUARD=0 instance, then a job that must clear ovf.
        terms_q = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
        pat_q   = '{1'b1, 1'b1};
        do_job(2, 1);
        terms_q = '{64'd5};
        do_job(1, 0);

        // Reset mid-job after 2 of 5 terms.
        d_start = 1'b1;
        d_len   = LW'(5);
        tick();
        d_start = 1'b0;
        d_valid = 1'b1;
        d_din   = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        tick();
        d_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        terms_q = '{64'd7};
        pat_q   = '{1'b1};
        do_job(1, 0);

        // Randomized jobs.
        for (int j = 0; j < 30; j++) begin
            int len;
            len = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 2) == 0) terms_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
                else                           terms_q.push_back({$urandom, $urandom});
            end
            do_job(len, int'($urandom_range(0, 3)));
        end

        repeat (3) tick();
        check("a_queue_drained", 128'(qa.size()), 0);
        check("b_queue_drained", 128'(qb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
